// File: rtl/riscmakers_icache_tag_ctrl.sv
// Lookup/refill/flush controller in front of the icache tag store SRAM (1-cycle read latency).
// Optional reset-time invalidation walk: RISCMAKERS_ICACHE_FLUSH_ON_RESET_EN.
module riscmakers_icache_tag_ctrl #(
  parameter int NUM_WORDS  = 256,
  parameter int TAG_WIDTH  = 20,
  parameter int DATA_WIDTH = 24,
  parameter int VALID_BIT  = 23,
  localparam int IDX_W     = $clog2(NUM_WORDS),
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IDX_W-1:0]      req_index_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_hit_o,
  output logic [IDX_W-1:0]      rsp_index_o,
  input  logic                  fill_valid_i,
  output logic                  fill_ready_o,
  input  logic [IDX_W-1:0]      fill_index_i,
  input  logic [TAG_WIDTH-1:0]  fill_tag_i,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic                  ts_en_o,
  output logic                  ts_we_o,
  output logic [BE_W-1:0]       ts_be_o,
  output logic [IDX_W-1:0]      ts_addr_o,
  output logic [DATA_WIDTH-1:0] ts_wdata_o,
  input  logic [DATA_WIDTH-1:0] ts_rdata_i
);

  typedef enum logic [1:0] {FLUSH, IDLE, LOOKUP} state_e;

  localparam int VALID_BYTE = VALID_BIT / 8;
  localparam logic [BE_W-1:0] FLUSH_BE = BE_W'(1) << VALID_BYTE;

`ifdef RISCMAKERS_ICACHE_FLUSH_ON_RESET_EN
  localparam state_e RESET_STATE = FLUSH;
  localparam logic   RESET_BUSY  = 1'b1;
`else
  localparam state_e RESET_STATE = IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     flush_idx_q, flush_idx_d;
  logic [IDX_W-1:0]     index_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 lookup_acc;
  logic                 flush_last;
  logic                 tag_match;
  logic [DATA_WIDTH-1:0] fill_wdata;
  logic                 unused_rdata;

  assign flush_last   = (flush_idx_q == IDX_W'(NUM_WORDS - 1));
  assign tag_match    = ts_rdata_i[VALID_BIT] && (ts_rdata_i[TAG_WIDTH-1:0] == tag_q);
  // Only the valid flag and tag field are meaningful; the rest is don't-care.
  assign unused_rdata = ^ts_rdata_i;

  always_comb begin
    fill_wdata                 = '0;
    fill_wdata[TAG_WIDTH-1:0]  = fill_tag_i;
    fill_wdata[VALID_BIT]      = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    flush_idx_d  = flush_idx_q;
    lookup_acc   = 1'b0;
    req_ready_o  = 1'b0;
    fill_ready_o = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_hit_o    = 1'b0;
    rsp_index_o  = index_q;
    flush_busy_o = 1'b0;
    ts_en_o      = 1'b0;
    ts_we_o      = 1'b0;
    ts_be_o      = '0;
    ts_addr_o    = '0;
    ts_wdata_o   = '0;

    if (!rst_ni) begin
      // Outputs are held quiet while reset is asserted, whatever the registered state.
      flush_busy_o = RESET_BUSY;
      rsp_index_o  = '0;
    end else begin
      case (state_q)
        FLUSH: begin
          flush_busy_o = 1'b1;
          ts_en_o      = 1'b1;
          ts_we_o      = 1'b1;
          ts_be_o      = FLUSH_BE;
          ts_addr_o    = flush_idx_q;
          if (flush_i) begin
            flush_idx_d = '0;
          end else if (flush_last) begin
            flush_idx_d = '0;
            state_d     = IDLE;
          end else begin
            flush_idx_d = flush_idx_q + IDX_W'(1);
          end
        end
        default: begin
          if (state_q == LOOKUP) begin
            rsp_valid_o = 1'b1;
            rsp_hit_o   = tag_match;
          end
          fill_ready_o = !flush_i;
          req_ready_o  = !flush_i && !fill_valid_i;
          state_d      = IDLE;
          if (flush_i) begin
            state_d     = FLUSH;
            flush_idx_d = '0;
          end else if (fill_valid_i) begin
            ts_en_o    = 1'b1;
            ts_we_o    = 1'b1;
            ts_be_o    = '1;
            ts_addr_o  = fill_index_i;
            ts_wdata_o = fill_wdata;
          end else if (req_valid_i) begin
            ts_en_o    = 1'b1;
            ts_addr_o  = req_index_i;
            lookup_acc = 1'b1;
            state_d    = LOOKUP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= RESET_STATE;
      flush_idx_q <= '0;
      index_q     <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      if (lookup_acc) begin
        index_q <= req_index_i;
        tag_q   <= req_tag_i;
      end
    end
  end

endmodule

// File: tb/tb_riscmakers_icache_tag_ctrl.sv
// Bench for riscmakers_icache_tag_ctrl: behavioural tag store, expected-response and
// expected-write queues checked by a monitor on the falling edge.
module tb_riscmakers_icache_tag_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [7:0]  req_index_i;
  logic [19:0] req_tag_i;
  logic        rsp_valid_o, rsp_hit_o;
  logic [7:0]  rsp_index_o;
  logic        fill_valid_i, fill_ready_o;
  logic [7:0]  fill_index_i;
  logic [19:0] fill_tag_i;
  logic        flush_i, flush_busy_o;
  logic        ts_en_o, ts_we_o;
  logic [2:0]  ts_be_o;
  logic [7:0]  ts_addr_o;
  logic [23:0] ts_wdata_o;
  logic [23:0] ts_rdata_i = '0;

  typedef struct { logic [7:0] idx; logic hit; } rsp_t;
  typedef struct { logic [7:0] addr; logic [2:0] be; logic [23:0] wd; } wr_t;

  rsp_t exp_rsp[$];
  wr_t  exp_wr[$];
  int   vecs = 0;
  int   errs = 0;
  logic [23:0] mem [256];

  riscmakers_icache_tag_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_index_i(req_index_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_index_o(rsp_index_o),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
    .fill_index_i(fill_index_i), .fill_tag_i(fill_tag_i),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .ts_en_o(ts_en_o), .ts_we_o(ts_we_o), .ts_be_o(ts_be_o),
    .ts_addr_o(ts_addr_o), .ts_wdata_o(ts_wdata_o), .ts_rdata_i(ts_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  // Tag store: registered read, byte-enabled write.
  always @(posedge clk_i) begin
    if (ts_en_o) begin
      if (ts_we_o) begin
        for (int b = 0; b < 3; b++)
          if (ts_be_o[b]) mem[ts_addr_o][b*8 +: 8] <= ts_wdata_o[b*8 +: 8];
      end else begin
        ts_rdata_i <= mem[ts_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_rsp(input logic [7:0] idx, input logic hit);
    rsp_t r;
    r.idx = idx; r.hit = hit;
    exp_rsp.push_back(r);
  endtask

  task automatic push_wr(input logic [7:0] addr, input logic [2:0] be, input logic [23:0] wd);
    wr_t w;
    w.addr = addr; w.be = be; w.wd = wd;
    exp_wr.push_back(w);
  endtask

  task automatic push_flush(input int last);
    for (int i = 0; i <= last; i++) push_wr(8'(i), 3'b100, 24'h0);
  endtask

  // Monitor: every response and every tag store write is matched against the queues.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (rsp_valid_o) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_index", rsp_index_o, r.idx);
          chk("rsp_hit", rsp_hit_o, r.hit);
        end
      end
      if (ts_en_o && ts_we_o) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", ts_addr_o, 32'hFFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", ts_addr_o, w.addr);
          chk("wr_be", ts_be_o, w.be);
          chk("wr_data", ts_wdata_o, w.wd);
        end
      end
    end
  end

  task automatic lookup(input logic [7:0] idx, input logic [19:0] tag, input logic hit);
    tick();
    req_valid_i = 1'b1; req_index_i = idx; req_tag_i = tag;
    fill_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("req_ready", req_ready_o, 1);
    push_rsp(idx, hit);
  endtask

  task automatic idle();
    tick();
    req_valid_i = 1'b0; fill_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_ni = 1'b0;
    req_valid_i = 1'b1; req_index_i = 8'd9; req_tag_i = 20'h1;
    fill_valid_i = 1'b1; fill_index_i = 8'd9; fill_tag_i = 20'h1; flush_i = 1'b0;
    repeat (3) tick();
    chk("rst_ts_en", ts_en_o, 0);
    chk("rst_ts_we", ts_we_o, 0);
    chk("rst_ts_be", ts_be_o, 0);
    chk("rst_ts_addr", ts_addr_o, 0);
    chk("rst_ts_wdata", ts_wdata_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_hit", rsp_hit_o, 0);
    chk("rst_rsp_index", rsp_index_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_fill_ready", fill_ready_o, 0);
`ifdef RISCMAKERS_ICACHE_FLUSH_ON_RESET_EN
    chk("rst_flush_busy", flush_busy_o, 1);
    push_flush(255);
`else
    chk("rst_flush_busy", flush_busy_o, 0);
`endif
    tick();
    rst_ni = 1'b1; req_valid_i = 1'b0; fill_valid_i = 1'b0;
`ifdef RISCMAKERS_ICACHE_FLUSH_ON_RESET_EN
    n = 0;
    while (flush_busy_o && n < 400) begin n++; tick(); end
    chk("reset_flush_cycles", n, 256);
    chk("reset_flush_req_ready", req_ready_o, 1);
`endif
    idle();

    // Miss, fill, hit, tag mismatch.
    lookup(8'd5, 20'h12345, 1'b0);
    tick();
    req_valid_i = 1'b0; fill_valid_i = 1'b1; fill_index_i = 8'd5; fill_tag_i = 20'h12345;
    #1;
    chk("fill_ready", fill_ready_o, 1);
    push_wr(8'd5, 3'b111, 24'h812345);
    lookup(8'd5, 20'h12345, 1'b1);
    lookup(8'd5, 20'h12346, 1'b0);

    // Back-to-back lookups.
    lookup(8'd1, 20'h0, 1'b0);
    lookup(8'd2, 20'h0, 1'b0);
    lookup(8'd3, 20'h0, 1'b0);
    idle();

    // Fill beats lookup; lookup follows next cycle and hits.
    tick();
    fill_valid_i = 1'b1; fill_index_i = 8'd7; fill_tag_i = 20'hABCDE;
    req_valid_i = 1'b1; req_index_i = 8'd7; req_tag_i = 20'hABCDE;
    #1;
    chk("prio_fill_ready", fill_ready_o, 1);
    chk("prio_req_ready", req_ready_o, 0);
    push_wr(8'd7, 3'b111, 24'h8ABCDE);
    lookup(8'd7, 20'hABCDE, 1'b1);
    idle();

    // Flush with a pending hit, restarted at index 100.
    lookup(8'd5, 20'h12345, 1'b1);
    tick();
    req_valid_i = 1'b1; req_index_i = 8'd6; flush_i = 1'b1;
    #1;
    chk("flush_req_ready", req_ready_o, 0);
    chk("flush_fill_ready", fill_ready_o, 0);
    push_flush(100);
    tick();
    req_valid_i = 1'b0; flush_i = 1'b0;
    repeat (100) tick();
    flush_i = 1'b1;
    #1;
    chk("flush_busy_mid", flush_busy_o, 1);
    chk("flush_addr_100", ts_addr_o, 100);
    push_flush(255);
    tick();
    flush_i = 1'b0;
    n = 0;
    while (flush_busy_o && n < 400) begin n++; tick(); end
    chk("flush_restart_cycles", n, 256);
    chk("post_flush_req_ready", req_ready_o, 1);
    lookup(8'd5, 20'h12345, 1'b0);
    lookup(8'd7, 20'hABCDE, 1'b0);
    idle();
    repeat (3) tick();
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
